// File: rtl/mbus_halt_master_if.sv
// Main 6809 bus and request/response signals of the HALT bus master.
// Optional grant timeout is enabled by defining MBUS_GRANT_TIMEOUT_EN.
interface mbus_halt_master_if;
    logic        E;
    logic        BA;
    logic        BS;
    logic        GHn;
    logic        BUS_OE;
    logic [15:0] MADDR;
    logic [7:0]  MDATA_OUT;
    logic [7:0]  MDATA_IN;
    logic        RWn;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WR;
    logic [15:0] REQ_ADDR;
    logic [7:0]  REQ_WDATA;
    logic        REQ_LAST;
    logic        RSP_VALID;
    logic [7:0]  RSP_RDATA;
    logic        ERR;
    logic        OWNED;

    modport master (
        input  E, BA, BS, MDATA_IN,
        input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, REQ_LAST,
        output GHn, BUS_OE, MADDR, MDATA_OUT, RWn,
        output REQ_READY, RSP_VALID, RSP_RDATA, ERR, OWNED
    );

    modport slave (
        output E, BA, BS, MDATA_IN,
        output REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, REQ_LAST,
        input  GHn, BUS_OE, MADDR, MDATA_OUT, RWn,
        input  REQ_READY, RSP_VALID, RSP_RDATA, ERR, OWNED
    );
endinterface

// File: rtl/mbus_halt_master.sv
// Secondary 6809 bus master: halts the CPU, then runs one byte access per E.
// Define MBUS_GRANT_TIMEOUT_EN to abort a HALT request that is never granted.
module mbus_halt_master #(
    parameter int unsigned GRANT_TIMEOUT = 64,
    parameter logic [15:0] IDLE_ADDR     = 16'hFFFF
) (
    input logic CLKSYS,
    input logic RESETn,
    mbus_halt_master_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT_REQ,
        ST_OWN,
        ST_ACCESS,
        ST_RELEASE
    } state_t;

    state_t state;
    logic   e_q;
    logic   e_fall;
    logic   grant;
    logic   accept;
    logic   to_hit;
    logic   acc_wr;
    logic   acc_last;

    assign e_fall = e_q & ~bus.E;
    assign grant  = bus.BA & bus.BS;

    // A request is taken in OWN, or back-to-back at the end of a non-last access.
    assign accept = e_fall & grant & bus.REQ_VALID &
                    ((state == ST_OWN) |
                     ((state == ST_ACCESS) & ~acc_last));

    assign bus.REQ_READY = accept | to_hit;

    // Previous E level for falling-edge detection.
    always_ff @(posedge CLKSYS or negedge RESETn) begin
        if (!RESETn) e_q <= 1'b0;
        else         e_q <= bus.E;
    end

`ifdef MBUS_GRANT_TIMEOUT_EN
    localparam int CNT_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;

    logic [CNT_W-1:0] to_cnt;

    assign to_hit = (state == ST_HALT_REQ) & e_fall & ~grant &
                    (to_cnt == CNT_W'(GRANT_TIMEOUT - 1));

    // Counts ungranted E falls while the HALT request is pending.
    always_ff @(posedge CLKSYS or negedge RESETn) begin
        if (!RESETn)                     to_cnt <= '0;
        else if (state != ST_HALT_REQ)   to_cnt <= '0;
        else if (e_fall && !grant)       to_cnt <= to_cnt + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    // Bus tenure FSM with registered bus and response outputs.
    always_ff @(posedge CLKSYS or negedge RESETn) begin
        if (!RESETn) begin
            state         <= ST_IDLE;
            bus.GHn       <= 1'b1;
            bus.BUS_OE    <= 1'b0;
            bus.MADDR     <= IDLE_ADDR;
            bus.MDATA_OUT <= 8'h00;
            bus.RWn       <= 1'b1;
            bus.RSP_VALID <= 1'b0;
            bus.RSP_RDATA <= 8'h00;
            bus.ERR       <= 1'b0;
            bus.OWNED     <= 1'b0;
            acc_wr        <= 1'b0;
            acc_last      <= 1'b0;
        end else begin
            bus.RSP_VALID <= 1'b0;
            if (accept) begin
                bus.ERR       <= 1'b0;
                acc_wr        <= bus.REQ_WR;
                acc_last      <= bus.REQ_LAST;
                bus.MADDR     <= bus.REQ_ADDR;
                bus.RWn       <= ~bus.REQ_WR;
                bus.MDATA_OUT <= bus.REQ_WDATA;
            end
            unique case (state)
                ST_IDLE: begin
                    if (bus.REQ_VALID) begin
                        state   <= ST_HALT_REQ;
                        bus.GHn <= 1'b0;
                    end
                end
                ST_HALT_REQ: begin
                    if (e_fall && grant) begin
                        state      <= ST_OWN;
                        bus.BUS_OE <= 1'b1;
                        bus.OWNED  <= 1'b1;
                        bus.MADDR  <= IDLE_ADDR;
                        bus.RWn    <= 1'b1;
                    end else if (to_hit) begin
                        state         <= ST_RELEASE;
                        bus.GHn       <= 1'b1;
                        bus.ERR       <= 1'b1;
                        bus.RSP_VALID <= 1'b1;
                        bus.RSP_RDATA <= 8'hFF;
                    end
                end
                ST_OWN, ST_ACCESS: begin
                    if (e_fall) begin
                        if (!grant) begin
                            // CPU took the bus back: abort, no response.
                            state      <= ST_RELEASE;
                            bus.GHn    <= 1'b1;
                            bus.BUS_OE <= 1'b0;
                            bus.OWNED  <= 1'b0;
                            bus.ERR    <= 1'b1;
                            bus.MADDR  <= IDLE_ADDR;
                            bus.RWn    <= 1'b1;
                        end else if (state == ST_ACCESS) begin
                            bus.RSP_VALID <= 1'b1;
                            if (!acc_wr) bus.RSP_RDATA <= bus.MDATA_IN;
                            if (acc_last) begin
                                state      <= ST_RELEASE;
                                bus.GHn    <= 1'b1;
                                bus.BUS_OE <= 1'b0;
                                bus.OWNED  <= 1'b0;
                                bus.MADDR  <= IDLE_ADDR;
                                bus.RWn    <= 1'b1;
                            end else if (!bus.REQ_VALID) begin
                                state     <= ST_OWN;
                                bus.MADDR <= IDLE_ADDR;
                                bus.RWn   <= 1'b1;
                            end
                        end else if (bus.REQ_VALID) begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (e_fall && !bus.BA) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbus_halt_master.sv
// Directed bench for mbus_halt_master: read, burst, gap, grant loss, reset.
// Timeout steps run only when MBUS_GRANT_TIMEOUT_EN is defined.
module tb_mbus_halt_master;

    logic clk = 1'b0;
    logic rst_n;
    logic ef;
    int   errors = 0;
    int   checks = 0;

    mbus_halt_master_if bus_if ();

    mbus_halt_master #(
        .GRANT_TIMEOUT(4),
        .IDLE_ADDR    (16'hFFFF)
    ) dut (
        .CLKSYS(clk),
        .RESETn(rst_n),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    // E: 2 clocks high, 2 low; ef marks the cycle in which the DUT sees the fall.
    initial begin
        bus_if.E = 1'b1;
        ef = 1'b0;
        forever begin
            repeat (2) @(posedge clk);
            #1 bus_if.E = 1'b0;
            ef = 1'b1;
            @(posedge clk);
            #1 ef = 1'b0;
            @(posedge clk);
            #1 bus_if.E = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic next_fall();
        int n;
        n = 0;
        @(negedge clk);
        while (!ef && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!ef) begin
            checks++;
            errors++;
            $error("FAIL e_fall_wait: observed timeout expected fall");
        end
    endtask

    task automatic req(input logic wr, input logic [15:0] a,
                       input logic [7:0] d, input logic last);
        bus_if.REQ_VALID = 1'b1;
        bus_if.REQ_WR    = wr;
        bus_if.REQ_ADDR  = a;
        bus_if.REQ_WDATA = d;
        bus_if.REQ_LAST  = last;
    endtask

    task automatic set_ba(input logic v);
        bus_if.BA = v;
        bus_if.BS = v;
    endtask

    initial begin
        rst_n = 1'b0;
        set_ba(1'b0);
        bus_if.MDATA_IN  = 8'h00;
        bus_if.REQ_VALID = 1'b0;
        bus_if.REQ_WR    = 1'b0;
        bus_if.REQ_ADDR  = 16'h0000;
        bus_if.REQ_WDATA = 8'h00;
        bus_if.REQ_LAST  = 1'b0;

        // Reset values
        repeat (3) step();
        chk("rst_ghn", bus_if.GHn, 1'b1);
        chk("rst_oe", bus_if.BUS_OE, 1'b0);
        chk("rst_addr", bus_if.MADDR, 16'hFFFF);
        chk("rst_wdata", bus_if.MDATA_OUT, 8'h00);
        chk("rst_rwn", bus_if.RWn, 1'b1);
        chk("rst_ready", bus_if.REQ_READY, 1'b0);
        chk("rst_rspv", bus_if.RSP_VALID, 1'b0);
        chk("rst_rdata", bus_if.RSP_RDATA, 8'h00);
        chk("rst_err", bus_if.ERR, 1'b0);
        chk("rst_owned", bus_if.OWNED, 1'b0);
        rst_n = 1'b1;
        step();

        // Single read, grant after 3 E cycles
        next_fall();
        req(1'b0, 16'hFC80, 8'h00, 1'b1);
        step();
        chk("rd_ghn_low", bus_if.GHn, 1'b0);
        chk("rd_oe_wait", bus_if.BUS_OE, 1'b0);
        for (int k = 0; k < 3; k++) begin
            next_fall();
            #1 chk("rd_wait_ready", bus_if.REQ_READY, 1'b0);
            chk("rd_wait_ghn", bus_if.GHn, 1'b0);
        end
        step();
        set_ba(1'b1);
        next_fall();
        #1 chk("rd_grant_ready", bus_if.REQ_READY, 1'b0);
        step();
        chk("rd_own_oe", bus_if.BUS_OE, 1'b1);
        chk("rd_own_owned", bus_if.OWNED, 1'b1);
        chk("rd_own_addr", bus_if.MADDR, 16'hFFFF);
        chk("rd_own_rwn", bus_if.RWn, 1'b1);
        next_fall();
        #1 chk("rd_accept", bus_if.REQ_READY, 1'b1);
        step();
        chk("rd_addr", bus_if.MADDR, 16'hFC80);
        chk("rd_rwn", bus_if.RWn, 1'b1);
        bus_if.REQ_VALID = 1'b0;
        bus_if.REQ_ADDR  = 16'h0000;
        bus_if.MDATA_IN  = 8'h5A;
        next_fall();
        #1 chk("rd_done_ready", bus_if.REQ_READY, 1'b0);
        chk("rd_addr_held", bus_if.MADDR, 16'hFC80);
        chk("rd_ghn_held", bus_if.GHn, 1'b0);
        step();
        chk("rd_rspv", bus_if.RSP_VALID, 1'b1);
        chk("rd_rdata", bus_if.RSP_RDATA, 8'h5A);
        chk("rd_rel_ghn", bus_if.GHn, 1'b1);
        chk("rd_rel_oe", bus_if.BUS_OE, 1'b0);
        chk("rd_rel_owned", bus_if.OWNED, 1'b0);
        step();
        chk("rd_rspv_pulse", bus_if.RSP_VALID, 1'b0);
        chk("rd_rdata_hold", bus_if.RSP_RDATA, 8'h5A);
        set_ba(1'b0);
        next_fall();

        // Burst of 4 writes, back-to-back
        next_fall();
        req(1'b1, 16'hC000, 8'h01, 1'b0);
        set_ba(1'b1);
        next_fall();
        #1 chk("wr_grant_ready", bus_if.REQ_READY, 1'b0);
        next_fall();
        #1 chk("wr_accept0", bus_if.REQ_READY, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wr_addr", bus_if.MADDR, 16'hC000 + 16'(i));
            chk("wr_data", bus_if.MDATA_OUT, 8'(i + 1));
            chk("wr_rwn", bus_if.RWn, 1'b0);
            chk("wr_rspv", bus_if.RSP_VALID, 1'(i > 0));
            if (i < 3)
                req(1'b1, 16'hC001 + 16'(i), 8'(i + 2), 1'(i == 2));
            else
                bus_if.REQ_VALID = 1'b0;
            next_fall();
            #1 chk("wr_ready", bus_if.REQ_READY, 1'(i < 3));
        end
        step();
        chk("wr_last_rspv", bus_if.RSP_VALID, 1'b1);
        chk("wr_rel_ghn", bus_if.GHn, 1'b1);
        chk("wr_rel_oe", bus_if.BUS_OE, 1'b0);
        set_ba(1'b0);
        next_fall();

        // Two reads with a two-E-cycle request gap
        next_fall();
        req(1'b0, 16'h1234, 8'h00, 1'b0);
        set_ba(1'b1);
        next_fall();
        next_fall();
        #1 chk("gap_accept1", bus_if.REQ_READY, 1'b1);
        step();
        bus_if.REQ_VALID = 1'b0;
        bus_if.MDATA_IN  = 8'hA5;
        next_fall();
        step();
        chk("gap_rspv1", bus_if.RSP_VALID, 1'b1);
        chk("gap_rdata1", bus_if.RSP_RDATA, 8'hA5);
        chk("gap_idle_addr", bus_if.MADDR, 16'hFFFF);
        chk("gap_idle_rwn", bus_if.RWn, 1'b1);
        chk("gap_ghn", bus_if.GHn, 1'b0);
        chk("gap_oe", bus_if.BUS_OE, 1'b1);
        next_fall();
        #1 chk("gap_no_ready", bus_if.REQ_READY, 1'b0);
        step();
        chk("gap_idle_addr2", bus_if.MADDR, 16'hFFFF);
        chk("gap_owned", bus_if.OWNED, 1'b1);
        chk("gap_ghn2", bus_if.GHn, 1'b0);
        req(1'b0, 16'h5678, 8'h00, 1'b1);
        next_fall();
        #1 chk("gap_accept2", bus_if.REQ_READY, 1'b1);
        step();
        chk("gap_addr2", bus_if.MADDR, 16'h5678);
        bus_if.REQ_VALID = 1'b0;
        bus_if.MDATA_IN  = 8'h3C;
        next_fall();
        step();
        chk("gap_rspv2", bus_if.RSP_VALID, 1'b1);
        chk("gap_rdata2", bus_if.RSP_RDATA, 8'h3C);
        chk("gap_rel_ghn", bus_if.GHn, 1'b1);
        set_ba(1'b0);
        next_fall();

        // Grant lost during ACCESS
        next_fall();
        req(1'b0, 16'h0100, 8'h00, 1'b0);
        set_ba(1'b1);
        next_fall();
        next_fall();
        #1 chk("gl_accept", bus_if.REQ_READY, 1'b1);
        step();
        bus_if.REQ_VALID = 1'b0;
        bus_if.BA = 1'b0;
        next_fall();
        #1 chk("gl_no_ready", bus_if.REQ_READY, 1'b0);
        step();
        chk("gl_oe", bus_if.BUS_OE, 1'b0);
        chk("gl_err", bus_if.ERR, 1'b1);
        chk("gl_no_rspv", bus_if.RSP_VALID, 1'b0);
        chk("gl_ghn", bus_if.GHn, 1'b1);
        chk("gl_owned", bus_if.OWNED, 1'b0);
        next_fall();
        req(1'b0, 16'h0200, 8'h00, 1'b1);
        step();
        chk("gl_rel_ignores_req", bus_if.GHn, 1'b1);
        chk("gl_err_sticky", bus_if.ERR, 1'b1);
        step();
        chk("gl_idle_rearm", bus_if.GHn, 1'b0);
        set_ba(1'b1);
        next_fall();
        next_fall();
        #1 chk("gl_accept2", bus_if.REQ_READY, 1'b1);
        step();
        chk("gl_err_clear", bus_if.ERR, 1'b0);
        bus_if.REQ_VALID = 1'b0;
        bus_if.MDATA_IN  = 8'h99;
        next_fall();
        step();
        chk("gl_rspv2", bus_if.RSP_VALID, 1'b1);
        chk("gl_rdata2", bus_if.RSP_RDATA, 8'h99);
        set_ba(1'b0);
        next_fall();

        // Asynchronous reset mid-burst
        next_fall();
        req(1'b1, 16'h3000, 8'hAA, 1'b0);
        set_ba(1'b1);
        next_fall();
        next_fall();
        #1 chk("ar_accept", bus_if.REQ_READY, 1'b1);
        step();
        chk("ar_oe_before", bus_if.BUS_OE, 1'b1);
        chk("ar_rwn_before", bus_if.RWn, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ghn", bus_if.GHn, 1'b1);
        chk("ar_oe", bus_if.BUS_OE, 1'b0);
        chk("ar_rwn", bus_if.RWn, 1'b1);
        chk("ar_addr", bus_if.MADDR, 16'hFFFF);
        chk("ar_owned", bus_if.OWNED, 1'b0);
        chk("ar_ready", bus_if.REQ_READY, 1'b0);
        bus_if.REQ_VALID = 1'b0;
        step();
        step();
        chk("ar_no_rspv", bus_if.RSP_VALID, 1'b0);
        rst_n = 1'b1;
        next_fall();
        req(1'b1, 16'h2000, 8'h77, 1'b1);
        set_ba(1'b1);
        next_fall();
        next_fall();
        #1 chk("ar_post_accept", bus_if.REQ_READY, 1'b1);
        step();
        chk("ar_post_addr", bus_if.MADDR, 16'h2000);
        chk("ar_post_data", bus_if.MDATA_OUT, 8'h77);
        chk("ar_post_rwn", bus_if.RWn, 1'b0);
        bus_if.REQ_VALID = 1'b0;
        next_fall();
        step();
        chk("ar_post_rspv", bus_if.RSP_VALID, 1'b1);
        chk("ar_post_ghn", bus_if.GHn, 1'b1);
        chk("ar_post_oe", bus_if.BUS_OE, 1'b0);
        set_ba(1'b0);
        next_fall();

`ifdef MBUS_GRANT_TIMEOUT_EN
        // Grant never arrives: abort after 4 E falls
        next_fall();
        req(1'b0, 16'h4000, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            next_fall();
            #1 chk("to_wait_ready", bus_if.REQ_READY, 1'b0);
            step();
            chk("to_wait_err", bus_if.ERR, 1'b0);
            chk("to_wait_ghn", bus_if.GHn, 1'b0);
        end
        next_fall();
        #1 chk("to_ready", bus_if.REQ_READY, 1'b1);
        step();
        chk("to_err", bus_if.ERR, 1'b1);
        chk("to_rspv", bus_if.RSP_VALID, 1'b1);
        chk("to_rdata", bus_if.RSP_RDATA, 8'hFF);
        chk("to_ghn", bus_if.GHn, 1'b1);
        bus_if.REQ_VALID = 1'b0;
        next_fall();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
